kernel_jacobi_2d_mul_arb: RTL and testbench

Shares one unsigned A_W×B_W multiplier (the stencil index multiplier, row×stride) between NREQ requesters in the jacobi-2d kernel. Each requester gets a valid/ready request port. A round-robin arbiter issues at most one operation per cycle into a stallable MUL_LAT-stage pipeline. Results come back on a single response port tagged with the requester ID; the response port supports backpressure.

---
 rtl/kernel_jacobi_2d_pkg.sv | 21 ++
 rtl/kernel_jacobi_2d_mul_pipe.sv | 56 +++++
 rtl/kernel_jacobi_2d_mul_arb.sv | 99 +++++++++
 tb/tb_kernel_jacobi_2d_mul_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_jacobi_2d_pkg.sv
// Shared widths, ID sizing and the stage record for the jacobi-2d index multiplier.
package kernel_jacobi_2d_pkg;

    localparam int DEF_A_W = 10;
    localparam int DEF_B_W = 11;
    localparam int DEF_P_W = 20;

    // Requester ID width; a single requester still gets a 1-bit ID.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic               valid;
        logic [2:0]         id;
        logic [DEF_A_W-1:0] a;
        logic [DEF_B_W-1:0] b;
        logic [DEF_P_W-1:0] p;
    } stage_t;

endpackage

// File: rtl/kernel_jacobi_2d_mul_pipe.sv
// Purpose: MUL_LAT-stage unsigned multiplier carrying {valid, id, product}.
// Latency: MUL_LAT enabled cycles from in_valid to out_valid.
// Backpressure: en low freezes every stage; rst clears all stages.
module kernel_jacobi_2d_mul_pipe #(
    parameter int A_W     = 10,
    parameter int B_W     = 11,
    parameter int P_W     = 20,
    parameter int ID_W    = 1,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    input  logic [A_W-1:0]  in_a,
    input  logic [B_W-1:0]  in_b,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [P_W-1:0]  out_p,
    output logic            any_valid
);

    logic [MUL_LAT-1:0] vld_q;
    logic [ID_W-1:0]    id_q [MUL_LAT];
    logic [P_W-1:0]     p_q  [MUL_LAT];
    logic [P_W-1:0]     prod;

    // Full A_W+B_W product, truncated to the low P_W bits on entry.
    assign prod = P_W'({{B_W{1'b0}}, in_a} * {{A_W{1'b0}}, in_b});

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                id_q[i] <= '0;
                p_q[i]  <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            p_q[0]   <= prod;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
                p_q[i]   <= p_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[MUL_LAT-1];
    assign out_id    = id_q[MUL_LAT-1];
    assign out_p     = p_q[MUL_LAT-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/kernel_jacobi_2d_mul_arb.sv
// Purpose: round-robin share of one row*stride multiplier among NREQ requesters.
// Latency: MUL_LAT cycles from accept to rsp_valid, plus one per stalled cycle.
// Backpressure: rsp_valid && !rsp_ready freezes the pipe and blocks all grants.
module kernel_jacobi_2d_mul_arb
    import kernel_jacobi_2d_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int A_W     = DEF_A_W,
    parameter int B_W     = DEF_B_W,
    parameter int P_W     = DEF_P_W,
    parameter int MUL_LAT = 3,
    localparam int ID_W   = id_width(NREQ)
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [P_W-1:0]      rsp_p,
    output logic                busy
);

    logic            adv;
    logic            accept;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W-1:0] gidx;
    logic [NREQ-1:0] grant;
    logic [A_W-1:0]  a_sel;
    logic [B_W-1:0]  b_sel;
    int              best;
    int              sel;

    assign adv = !(rsp_valid && !rsp_ready);

    // Pick the valid requester with the smallest distance above ptr (mod NREQ).
    always_comb begin
        int d;
        best    = NREQ;
        sel     = 0;
        grant   = '0;
        gidx    = '0;
        ptr_nxt = ptr;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = i - int'(ptr);
            if (d < 0) d = d + NREQ;
            if (req_valid[i] && d < best) begin
                best = d;
                sel  = i;
            end
        end
        if (adv && !ap_rst && best < NREQ) begin
            gidx    = ID_W'(sel);
            ptr_nxt = ID_W'((sel + 1 == NREQ) ? 0 : sel + 1);
            for (int i = 0; i < NREQ; i++) begin
                if (i == sel) begin
                    grant[i] = 1'b1;
                    a_sel    = req_a[i*A_W +: A_W];
                    b_sel    = req_b[i*B_W +: B_W];
                end
            end
        end
    end

    assign accept    = |grant;
    assign req_ready = grant;

    always_ff @(posedge ap_clk) begin
        if (ap_rst)      ptr <= '0;
        else if (accept) ptr <= ptr_nxt;
    end

    kernel_jacobi_2d_mul_pipe #(
        .A_W     (A_W),
        .B_W     (B_W),
        .P_W     (P_W),
        .ID_W    (ID_W),
        .MUL_LAT (MUL_LAT)
    ) u_pipe (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .en        (adv),
        .in_valid  (accept),
        .in_id     (gidx),
        .in_a      (a_sel),
        .in_b      (b_sel),
        .out_valid (rsp_valid),
        .out_id    (rsp_id),
        .out_p     (rsp_p),
        .any_valid (busy)
    );

endmodule

// File: tb/tb_kernel_jacobi_2d_mul_arb.sv
// Bench for the shared multiplier: directed scenarios plus random traffic against a queue model.
module tb_kernel_jacobi_2d_mul_arb;

    localparam int N   = 2;
    localparam int LAT = 3;
    localparam int PW  = 20;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [19:0] req_a = '0;
    logic [21:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [0:0]  rsp_id;
    logic [19:0] rsp_p;
    logic        busy;

    logic [2:0]  r3_valid = '0;
    logic [2:0]  r3_ready;
    logic [29:0] r3_a = '0;
    logic [32:0] r3_b = '0;
    logic        r3_rsp_valid;
    logic        r3_rsp_ready = 1'b1;
    logic [1:0]  r3_rsp_id;
    logic [19:0] r3_rsp_p;
    logic        r3_busy;

    int chk = 0;
    int err = 0;

    kernel_jacobi_2d_mul_arb dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_p(rsp_p), .busy(busy)
    );

    kernel_jacobi_2d_mul_arb #(.NREQ(3)) dut3 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_a(r3_a), .req_b(r3_b), .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready),
        .rsp_id(r3_rsp_id), .rsp_p(r3_rsp_p), .busy(r3_busy)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference model: in-flight operations in acceptance order, each with the
    // number of advancing edges it has seen; the head is visible once that reaches LAT.
    typedef struct {
        int     id;
        longint a;
        longint b;
        int     age;
    } ent_t;

    ent_t       q[$];
    int         mptr = 0;
    logic       e_vld;
    int         e_id;
    longint     e_p;
    logic       e_adv;
    int         e_g;
    logic [1:0] e_rdy;
    logic       e_busy;

    task automatic predict();
        e_vld = (q.size() > 0) && (q[0].age == LAT);
        e_id  = 0;
        e_p   = 0;
        if (e_vld) begin
            e_id = q[0].id;
            e_p  = (q[0].a * q[0].b) % (longint'(1) << PW);
        end
        e_adv = !(e_vld && !rsp_ready);
        e_g   = -1;
        if (e_adv && !ap_rst) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (e_g < 0 && req_valid[j]) e_g = j;
            end
        end
        e_rdy  = (e_g >= 0) ? (2'b01 << e_g) : 2'b00;
        e_busy = (q.size() > 0);
    endtask

    task automatic step();
        logic [19:0] ta;
        logic [21:0] tbv;
        ent_t        e;
        predict();
        ta  = req_a;
        tbv = req_b;
        @(posedge ap_clk);
        if (ap_rst) begin
            q.delete();
            mptr = 0;
        end else if (e_adv) begin
            if (e_vld && rsp_ready) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
            if (e_g >= 0) begin
                e.id  = e_g;
                e.a   = longint'(ta[e_g*10 +: 10]);
                e.b   = longint'(tbv[e_g*11 +: 11]);
                e.age = 1;
                q.push_back(e);
                mptr = (e_g + 1) % N;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic test_reset();
        @(negedge ap_clk);
        req_valid = 2'b11;
        r3_valid  = 3'b111;
        #1;
        chk++; if (req_ready !== 2'b00) begin err++; $display("FAIL rst_ready got %b exp 00", req_ready); end
        chk++; if (r3_ready !== 3'b000) begin err++; $display("FAIL rst_ready3 got %b exp 000", r3_ready); end
        chk++; if (rsp_valid !== 1'b0) begin err++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
        chk++; if (rsp_id !== 1'b0 || rsp_p !== 20'd0) begin
            err++; $display("FAIL rst_data got id=%0d p=%0d exp 0/0", rsp_id, rsp_p);
        end
        chk++; if (busy !== 1'b0 || r3_busy !== 1'b0) begin err++; $display("FAIL rst_busy got %b/%b exp 0/0", busy, r3_busy); end
        step();
        req_valid = 2'b00;
        r3_valid  = 3'b000;
        ap_rst    = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                req_valid = 2'b11;
                req_a = {10'(c), 10'(c)};
                req_b = {11'd2, 11'd2};
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (c < 8) begin
                chk++;
                if (req_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                    err++; $display("FAIL fair_grant c=%0d got %b", c, req_ready);
                end
            end
            chk++;
            if (rsp_valid !== (c >= 3 && c < 11)) begin
                err++; $display("FAIL fair_valid c=%0d got %b", c, rsp_valid);
            end
            if (c >= 3 && c < 11) begin
                chk++;
                if (rsp_id !== 1'((c - 3) % 2) || rsp_p !== 20'(2 * (c - 3))) begin
                    err++; $display("FAIL fair_rsp c=%0d got id=%0d p=%0d exp id=%0d p=%0d",
                                    c, rsp_id, rsp_p, (c - 3) % 2, 2 * (c - 3));
                end
            end
            step();
        end
    endtask

    task automatic test_single();
        req_valid = 2'b01;
        req_a = {10'd0, 10'd1023};
        req_b = {11'd0, 11'd2047};
        #1;
        chk++; if (req_ready !== 2'b01 || busy !== 1'b0) begin
            err++; $display("FAIL single_accept got ready=%b busy=%b exp 01/0", req_ready, busy);
        end
        step();
        req_valid = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk++; if (busy !== (c <= 3)) begin err++; $display("FAIL single_busy c=%0d got %b", c, busy); end
            chk++; if (rsp_valid !== (c == 3)) begin err++; $display("FAIL single_valid c=%0d got %b", c, rsp_valid); end
            if (c == 3) begin
                chk++;
                if (rsp_id !== 1'b0 || rsp_p !== 20'd1045505) begin
                    err++; $display("FAIL single_rsp got id=%0d p=%0d exp 0/1045505", rsp_id, rsp_p);
                end
            end
            step();
        end
    endtask

    task automatic test_bubbles();
        for (int c = 0; c < 7; c++) begin
            req_valid = (c == 0 || c == 2) ? 2'b10 : 2'b00;
            req_a = (c == 0) ? {10'd100, 10'd0} : {10'd1000, 10'd0};
            req_b = (c == 0) ? {11'd300, 11'd0} : {11'd2000, 11'd0};
            #1;
            chk++;
            if (rsp_valid !== (c == 3 || c == 5)) begin
                err++; $display("FAIL bubble_valid c=%0d got %b", c, rsp_valid);
            end
            if (c == 3 || c == 5) begin
                chk++;
                if (rsp_id !== 1'b1 || rsp_p !== ((c == 3) ? 20'd30000 : 20'd951424)) begin
                    err++; $display("FAIL bubble_rsp c=%0d got id=%0d p=%0d", c, rsp_id, rsp_p);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int          ba[4];
        int          bb[4];
        int          sent = 0;
        int          rcv = 0;
        int          stall_left = 0;
        bit          stall_done = 0;
        logic        held_id = 1'b0;
        logic [19:0] held_p = '0;
        for (int i = 0; i < 4; i++) begin
            ba[i] = $urandom_range(0, 1023);
            bb[i] = $urandom_range(0, 2047);
        end
        for (int c = 0; c < 20; c++) begin
            req_valid = (sent < 4) ? 2'b10 : 2'b00;
            if (sent < 4) begin
                req_a = {10'(ba[sent]), 10'd0};
                req_b = {11'(bb[sent]), 11'd0};
            end
            if (!stall_done && rsp_valid) begin
                stall_done = 1;
                stall_left = 5;
                held_id = rsp_id;
                held_p  = rsp_p;
            end
            rsp_ready = (stall_left == 0);
            #1;
            predict();
            chk++; if (req_ready !== e_rdy) begin err++; $display("FAIL bp_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
            chk++; if (rsp_valid !== e_vld) begin err++; $display("FAIL bp_valid c=%0d got %b exp %b", c, rsp_valid, e_vld); end
            if (stall_left > 0) begin
                chk++;
                if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== held_id || rsp_p !== held_p) begin
                    err++; $display("FAIL bp_hold c=%0d got rdy=%b v=%b id=%0d p=%0d exp 00/1/%0d/%0d",
                                    c, req_ready, rsp_valid, rsp_id, rsp_p, held_id, held_p);
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk++;
                if (rcv >= 4) begin
                    err++; $display("FAIL bp_extra c=%0d got p=%0d exp none", c, rsp_p);
                end else if (rsp_id !== 1'b1 || rsp_p !== 20'((longint'(ba[rcv]) * bb[rcv]) % (1 << 20))) begin
                    err++; $display("FAIL bp_rsp idx=%0d got p=%0d exp %0d", rcv, rsp_p,
                                    (longint'(ba[rcv]) * bb[rcv]) % (1 << 20));
                end
                rcv++;
            end
            if (req_valid[1] && req_ready[1]) sent++;
            step();
            if (stall_left > 0) stall_left--;
        end
        chk++; if (rcv != 4 || sent != 4) begin err++; $display("FAIL bp_count got rcv=%0d sent=%0d exp 4/4", rcv, sent); end
        rsp_ready = 1'b1;
    endtask

    task automatic test_mid_reset();
        int a0;
        int b0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 2'b11;
            req_a = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
            req_b = {11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047))};
            step();
        end
        ap_rst = 1'b1;
        #1;
        chk++; if (req_ready !== 2'b00) begin err++; $display("FAIL mrst_ready got %b exp 00", req_ready); end
        step();
        ap_rst = 1'b0;
        a0 = $urandom_range(1, 1023);
        b0 = $urandom_range(1, 2047);
        req_a = {10'd0, 10'(a0)};
        req_b = {11'd0, 11'(b0)};
        #1;
        chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            err++; $display("FAIL mrst_clear got valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
        chk++; if (req_ready !== 2'b01) begin err++; $display("FAIL mrst_ptr got %b exp 01", req_ready); end
        step();
        req_valid = 2'b00;
        for (int c = 1; c <= 6; c++) begin
            #1;
            chk++; if (rsp_valid !== (c == 3)) begin err++; $display("FAIL mrst_valid c=%0d got %b", c, rsp_valid); end
            if (c == 3) begin
                chk++;
                if (rsp_id !== 1'b0 || rsp_p !== 20'((longint'(a0) * b0) % (1 << 20))) begin
                    err++; $display("FAIL mrst_rsp got id=%0d p=%0d exp 0/%0d", rsp_id, rsp_p,
                                    (longint'(a0) * b0) % (1 << 20));
                end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        r3_a = {10'd7, 10'd9, 10'd5};
        r3_b = {11'd3, 11'd3, 11'd3};
        for (int c = 0; c < 10; c++) begin
            r3_valid = (c < 4) ? 3'b101 : ((c == 4) ? 3'b011 : 3'b000);
            #1;
            if (c < 5) begin
                chk++;
                if (r3_ready !== ((c % 2 == 0) ? 3'b001 : 3'b100)) begin
                    err++; $display("FAIL wrap_grant c=%0d got %b", c, r3_ready);
                end
            end
            chk++;
            if (r3_rsp_valid !== (c >= 3 && c <= 7)) begin
                err++; $display("FAIL wrap_valid c=%0d got %b", c, r3_rsp_valid);
            end
            if (c >= 3 && c <= 7) begin
                chk++;
                if (r3_rsp_id !== ((c % 2 == 1) ? 2'd0 : 2'd2) || r3_rsp_p !== ((c % 2 == 1) ? 20'd15 : 20'd21)) begin
                    err++; $display("FAIL wrap_rsp c=%0d got id=%0d p=%0d", c, r3_rsp_id, r3_rsp_p);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 20'($urandom);
            req_b     = 22'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            predict();
            chk++; if (req_ready !== e_rdy) begin err++; $display("FAIL rnd_ready c=%0d got %b exp %b", c, req_ready, e_rdy); end
            chk++; if (rsp_valid !== e_vld) begin err++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, rsp_valid, e_vld); end
            if (e_vld) begin
                chk++;
                if (rsp_id !== 1'(e_id) || rsp_p !== e_p[19:0]) begin
                    err++; $display("FAIL rnd_rsp c=%0d got id=%0d p=%0d exp id=%0d p=%0d", c, rsp_id, rsp_p, e_id, e_p);
                end
            end
            chk++; if (busy !== e_busy) begin err++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, e_busy); end
            step();
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (LAT + 2) step();
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_bubbles();
        test_backpressure();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
